// File: rtl/mac_result_display.sv
// Binary-to-BCD readout for the MAC result: sequential double-dabble conversion driving six
// active-low seven-segment displays plus the overflow LED.
module mac_result_display #(
    parameter int unsigned WIDTH    = 17,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4,
    output logic [6:0]       HEX5
);

    typedef enum logic [1:0] {StIdle, StConvert, StFinish} state_e;

    localparam logic [6:0] SegBlank = 7'h7F;
    localparam logic [6:0] SegZero  = 7'h40;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [23:0]      bcd_q, bcd_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [6:0]       hex_q [6];
    logic [6:0]       hex_d [6];

    logic [23:0]         bcd_adj;
    logic [WIDTH+23:0]   shifted;
    logic [5:0]          blank;

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3
                                                          : bcd_q[i*4 +: 4];
        end
        shifted = {bcd_adj, shift_q} << 1;

        // A digit blanks only when it and every digit above it are zero; HEX0 never blanks.
        blank[0] = 1'b0;
        blank[5] = (BLANK_LZ != 0) && (bcd_q[23:20] == 4'd0);
        for (int k = 4; k >= 1; k--) begin
            blank[k] = blank[k+1] && (bcd_q[k*4 +: 4] == 4'd0);
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        for (int i = 0; i < 6; i++) hex_d[i] = hex_q[i];

        unique case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse is dropped, not queued.
                if (start && !done_q) begin
                    shift_d = value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = value[WIDTH-1];
                    state_d = StConvert;
                end
            end
            StConvert: begin
                bcd_d   = shifted[WIDTH+23:WIDTH];
                shift_d = shifted[WIDTH-1:0];
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'(WIDTH - 1)) state_d = StFinish;
            end
            StFinish: begin
                for (int i = 0; i < 6; i++) begin
                    hex_d[i] = blank[i] ? SegBlank : seg(bcd_q[i*4 +: 4]);
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            hex_q[0] <= SegZero;
            for (int i = 1; i < 6; i++) hex_q[i] <= SegBlank;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            for (int i = 0; i < 6; i++) hex_q[i] <= hex_d[i];
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign ovf  = ovf_q;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_mac_result_display.sv
// Directed bench for mac_result_display: one instance with leading-zero blanking, one without,
// sharing the same inputs.
module tb_mac_result_display;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [16:0] value;

    logic       busy, done, ovf;
    logic [6:0] h0, h1, h2, h3, h4, h5;
    logic       nb_busy, nb_done, nb_ovf;
    logic [6:0] n0, n1, n2, n3, n4, n5;

    int checks = 0;
    int errors = 0;

    wire [41:0] hex_all = {h5, h4, h3, h2, h1, h0};
    wire [41:0] nb_all  = {n5, n4, n3, n2, n1, n0};

    always #5 clk = ~clk;

    mac_result_display #(.WIDTH(17), .BLANK_LZ(1)) dut (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(busy), .done(done), .ovf(ovf),
        .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4), .HEX5(h5)
    );

    mac_result_display #(.WIDTH(17), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .reset(reset), .start(start), .value(value),
        .busy(nb_busy), .done(nb_done), .ovf(nb_ovf),
        .HEX0(n0), .HEX1(n1), .HEX2(n2), .HEX3(n3), .HEX4(n4), .HEX5(n5)
    );

    localparam logic [41:0] HexReset = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start with v, then count edges to the done pulse and busy-high samples.
    task automatic do_conv(input logic [16:0] v, output int lat, output int busy_cnt);
        value = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; value = '0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b ovf=%b required 0 0 0", busy, done, ovf);
        end
        checks++;
        if (hex_all !== HexReset || nb_all !== HexReset) begin
            errors++;
            $display("FAIL reset_hex: got %h / %h required %h", hex_all, nb_all, HexReset);
        end
    endtask

    task automatic test_zero();
        int lat, bc;
        do_conv(17'd0, lat, bc);
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL zero_latency: got %0d required 18", lat);
        end
        checks++;
        if (hex_all !== HexReset || ovf !== 1'b0) begin
            errors++;
            $display("FAIL zero_hex: got %h ovf=%b required %h ovf=0", hex_all, ovf, HexReset);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL zero_done_width: done=%b required 0", done);
        end
    endtask

    task automatic test_12345();
        int lat, bc;
        do_conv(17'd12345, lat, bc);
        checks++;
        if (lat !== 18 || bc !== 18 || busy !== 1'b0) begin
            errors++;
            $display("FAIL 12345_timing: lat=%0d busy_cycles=%0d busy=%b required 18 18 0",
                     lat, bc, busy);
        end
        checks++;
        if (hex_all !== {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12} || ovf !== 1'b0) begin
            errors++;
            $display("FAIL 12345_hex: got %h ovf=%b", hex_all, ovf);
        end
        tick();
    endtask

    task automatic test_max();
        int lat, bc;
        do_conv(17'd131071, lat, bc);
        checks++;
        if (hex_all !== {7'h79, 7'h30, 7'h79, 7'h40, 7'h78, 7'h79} || ovf !== 1'b1) begin
            errors++;
            $display("FAIL max_hex: got %h ovf=%b required 79307940 7879 ovf=1", hex_all, ovf);
        end
        tick();
    endtask

    task automatic test_blanking();
        int lat, bc;
        logic [41:0] exp_int;
        exp_int = {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12};
        do_conv(17'd100005, lat, bc);
        checks++;
        if (hex_all !== exp_int || nb_all !== exp_int || ovf !== 1'b1) begin
            errors++;
            $display("FAIL interior_zero: got %h / %h ovf=%b required %h", hex_all, nb_all,
                     ovf, exp_int);
        end
        tick();
        do_conv(17'd7, lat, bc);
        checks++;
        if (nb_all !== {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78}) begin
            errors++;
            $display("FAIL no_blank_7: got %h", nb_all);
        end
        checks++;
        if (hex_all !== {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78} || ovf !== 1'b0) begin
            errors++;
            $display("FAIL blank_7: got %h ovf=%b", hex_all, ovf);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        int first = -1;
        value = 17'd12345;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 5) begin
                value = 17'd999;
                start = 1'b1;
            end else if (first > 0 && i == first + 1) begin
                // start again during the done cycle
                value = 17'd999;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                dones++;
                if (first < 0) first = i;
            end
        end
        start = 1'b0;
        checks++;
        if (dones !== 1 || first !== 18) begin
            errors++;
            $display("FAIL ignored_start: done_pulses=%0d first=%0d required 1 at 18",
                     dones, first);
        end
        checks++;
        if (hex_all !== {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12} || busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_hex: got %h busy=%b", hex_all, busy);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        int dones = 0;
        value = 17'd54321;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hex_all !== HexReset) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b hex=%h required 0 0 %h", busy, done,
                     hex_all, HexReset);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_no_done: done_pulses=%0d required 0", dones);
        end
        do_conv(17'd54321, lat, bc);
        checks++;
        if (lat !== 18 || hex_all !== {7'h7F, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}) begin
            errors++;
            $display("FAIL after_abort: lat=%0d hex=%h required 18 7f12193024 79", lat, hex_all);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_zero();
        test_12345();
        test_max();
        test_blanking();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_result_display.md
Name: mac_result_display

Overview:
- Readout side of the lab multiply-accumulate datapath. Captures the 17-bit result {Cout, sum}, where sum = a*b + c*d.
- Converts the captured value to six decimal digits with a sequential shift-add-3 (double-dabble) engine.
- Drives the six active-low seven-segment displays HEX5..HEX0 and the overflow LED.
- The converter runs on a start/done handshake, so the displays only change when a conversion completes.

Parameters:
- WIDTH, 17, binary input width; legal range 1..19 (result must fit in 6 decimal digits).
- BLANK_LZ, 1, 1 = blank leading zero digits (HEX0 always lit); 0 = show all six digits.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  reset, synchronous, active-high.
- start  input  1  request conversion of value; sampled only in IDLE.
- value  input  WIDTH  binary result to display; {Cout, sum} from the MAC.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  one-cycle pulse when the displays update.
- ovf  output  1  value[WIDTH-1] captured at start; drives LEDR[9].
- HEX0..HEX5  output  7 each  segment drives, active-low, bit0 = a .. bit6 = g; HEX0 = ones digit.

Behaviour:
- Reset, taking priority over everything including a conversion in progress:
  - state = IDLE; busy = 0, done = 0, ovf = 0.
  - HEX5..HEX1 = 7'h7F (blank).
  - HEX0 = 7'h40 ("0").
  - Internal shift and BCD registers cleared.
- FSM states: IDLE, CONVERT, FINISH.
- IDLE:
  - When start = 1 at a clock edge: capture value into the shift register, clear the 24-bit BCD register, clear the bit counter, latch ovf = value[WIDTH-1], go to CONVERT.
  - When start = 0: hold state; display outputs are unchanged.
- CONVERT, one bit per cycle:
  - Each BCD nibble >= 5 gets +3 (all six nibbles adjusted in parallel).
  - Then {bcd, shift} shifts left by 1.
  - Counter increments. After the WIDTH-th shift, go to FINISH.
- FINISH:
  - Register the six segment codes from the final BCD nibbles into HEX0..HEX5.
  - Assert done for exactly this one cycle (registered, so visible the cycle after the edge).
  - Return to IDLE.
- Latency, with start sampled at edge 0:
  - Shifts occur at edges 1..WIDTH.
  - HEX outputs and done change at edge WIDTH+1, which is 18 for the default width.
  - busy is high from edge 0 until edge WIDTH+1.
- start is ignored in CONVERT and FINISH; there is no queueing. start arriving in the same cycle done is high is also ignored.
- value may change freely after capture; only the captured copy is converted.
- Segment codes:
  - Digits 0..9 map to 40, 79, 24, 30, 19, 12, 02, 78, 00, 10 (hex).
  - Blank = 7F.
  - Nibbles > 9 cannot occur for legal WIDTH; if one does, it displays blank.
- Leading-zero blanking (BLANK_LZ = 1):
  - Digit k (k >= 1) is blanked iff it and all higher digits are 0.
  - Interior zeros are never blanked; HEX0 is never blanked.
- Reset asserted mid-CONVERT aborts the conversion: no done pulse, displays go to their reset values.

Test Plan:
- Reset, then start with value = 0 -> after 18 cycles done = 1 for 1 cycle; HEX0 = 40, HEX1..HEX5 = 7F, ovf = 0.
- value = 12345 -> HEX4..HEX0 = 79, 24, 30, 19, 12; HEX5 = 7F; ovf = 0; done exactly 18 cycles after start edge; busy high for 18 cycles.
- value = 131071 (max, Cout = 1) -> HEX5..HEX0 = 79, 30, 79, 40, 78, 79; ovf = 1.
- value = 100005 -> HEX5..HEX0 = 79, 40, 40, 40, 40, 12 (interior zeros shown); same value with BLANK_LZ = 0 and value = 7 -> HEX5..HEX1 = 40, HEX0 = 78.
- Convert 12345, then during busy pulse start with value = 999 -> ignored; displays show 12345 and only one done pulse occurs.
- Display 12345, start a conversion of 54321, assert reset at cycle 9 -> no done pulse; HEX0 = 40, others 7F, busy = 0; next start with 54321 completes normally.
